pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - write-back source encodings of the instruction in ID/EX
//   - stall/flush bit indices (one bit per pipeline stage) and composite masks
//   - controller state encodings
package pipe_ctrl_pkg;

    // Write-back source of an instruction.
    localparam logic [1:0] RW_NONE = 2'd0;
    localparam logic [1:0] RW_ALU  = 2'd1;
    localparam logic [1:0] RW_RAM  = 2'd2;

    // Stage bit indices, shared by stall_o and flush_o.
    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IF_ID = 1;
    localparam int unsigned STG_ID_EX = 2;
    localparam int unsigned STG_EX_MEM = 3;
    localparam int unsigned STG_MEM_WB = 4;
    localparam int unsigned STG_WB    = 5;

    localparam int unsigned STG_W = 6;

    // Memory wait freezes everything up to and including EX/MEM.
    localparam logic [STG_W-1:0] STALL_MEM_MASK =
        (6'(1) << STG_PC) | (6'(1) << STG_IF_ID) |
        (6'(1) << STG_ID_EX) | (6'(1) << STG_EX_MEM);

    // Load-use holds PC and IF/ID and drops a bubble into ID/EX.
    localparam logic [STG_W-1:0] STALL_LU_MASK = (6'(1) << STG_PC) | (6'(1) << STG_IF_ID);
    localparam logic [STG_W-1:0] FLUSH_LU_MASK = 6'(1) << STG_ID_EX;

    // Taken branch squashes the wrong-path instruction in IF/ID.
    localparam logic [STG_W-1:0] FLUSH_BR_MASK = 6'(1) << STG_IF_ID;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_FLUSH   = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Flags when the instruction in ID/EX loads from memory into a register that
// the instruction in IF/ID reads. Register r0 is hard-wired zero and never
// creates a hazard.
//   id_rs_i, id_rt_i : source register fields of the IF/ID instruction
//   ex_rw_i          : destination register of the ID/EX instruction
//   ex_rw_src_i      : write-back source of the ID/EX instruction
//   load_use_o       : hazard present this cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [4:0] ex_rw_i,
    input  logic [1:0] ex_rw_src_i,
    output logic       load_use_o
);

    assign load_use_o = (ex_rw_src_i == RW_RAM) && (ex_rw_i != 5'd0) &&
                        ((ex_rw_i == id_rs_i) || (ex_rw_i == id_rt_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller.
// Produces same-cycle per-stage stall and flush controls from a registered
// state plus the current hazard inputs, and counts stalled cycles.
//   clk, rst_n    : clock, asynchronous active-low reset
//   id_rs_i/rt_i  : source fields of the IF/ID instruction
//   ex_rw_i       : destination of the ID/EX instruction
//   ex_rw_src_i   : write-back source of the ID/EX instruction
//   br_taken_i    : taken branch/jump resolved in EX
//   mem_req_i     : data-memory access in MEM
//   mem_ready_i   : data memory completes this cycle
//   stall_o       : per-stage hold (bit0 PC .. bit5 WB)
//   flush_o       : per-stage bubble insert, same mapping
//   state_o       : registered controller state
//   stall_cnt_o   : saturating count of cycles with any stall bit set
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       ex_rw_i,
    input  logic [1:0]       ex_rw_src_i,
    input  logic             br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic [STG_W-1:0] stall_o,
    output logic [STG_W-1:0] flush_o,
    output logic [1:0]       state_o,
    output logic [15:0]      stall_cnt_o
);

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;
    logic        mem_wait;

    hazard_detect u_hazard_detect (
        .id_rs_i     (id_rs_i),
        .id_rt_i     (id_rt_i),
        .ex_rw_i     (ex_rw_i),
        .ex_rw_src_i (ex_rw_src_i),
        .load_use_o  (load_use)
    );

    assign mem_wait = mem_req_i & ~mem_ready_i;

    // Next state and output decode. Outputs are also gated by rst_n so that
    // asserting reset silences the controls in the same instant, not only
    // after the state register clears.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        stall_o = '0;
        flush_o = '0;
        if (rst_n) begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        stall_o = STALL_MEM_MASK;
                        state_d = ST_MEM_WAIT;
                    end else if (br_taken_i) begin
                        // The IF/ID instruction is wrong-path, so a coincident
                        // load-use is irrelevant.
                        flush_o = FLUSH_BR_MASK;
                        state_d = ST_BR_FLUSH;
                    end else if (load_use) begin
                        stall_o = STALL_LU_MASK;
                        flush_o = FLUSH_LU_MASK;
                        state_d = ST_LOAD_STALL;
                    end
                end
                ST_LOAD_STALL: begin
                    // Bubble already inserted; the load has moved on, so the
                    // hazard is not re-checked here.
                    if (mem_wait) begin
                        stall_o = STALL_MEM_MASK;
                        state_d = ST_MEM_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_BR_FLUSH: begin
                    // Second flush cycle is held pending across a memory wait.
                    if (mem_wait) begin
                        stall_o = STALL_MEM_MASK;
                    end else begin
                        flush_o = FLUSH_BR_MASK;
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_wait) begin
                        stall_o = STALL_MEM_MASK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_o != '0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // NOTE: asynchronous active-low reset is listed in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. Inputs change 1 ns after a
// rising edge; combinational outputs are checked 1 ns later, registered
// values 1 ns after the following edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs_i, id_rt_i, ex_rw_i;
    logic [1:0]  ex_rw_src_i;
    logic        br_taken_i, mem_req_i, mem_ready_i;
    logic [5:0]  stall_o, flush_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs_i     (id_rs_i),
        .id_rt_i     (id_rt_i),
        .ex_rw_i     (ex_rw_i),
        .ex_rw_src_i (ex_rw_src_i),
        .br_taken_i  (br_taken_i),
        .mem_req_i   (mem_req_i),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .state_o     (state_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all hazard inputs, then let combinational logic settle.
    task automatic drv(input logic [1:0] src, input logic [4:0] rw, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic req, input logic rdy);
        ex_rw_src_i = src;
        ex_rw_i     = rw;
        id_rs_i     = rs;
        id_rt_i     = rt;
        br_taken_i  = br;
        mem_req_i   = req;
        mem_ready_i = rdy;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] st, input logic [5:0] fl);
        check({tag, "_stall"}, 16'(stall_o), 16'(st));
        check({tag, "_flush"}, 16'(flush_o), 16'(fl));
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset with a memory wait on the inputs: outputs must still be zero.
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_out("rst", 6'b000000, 6'b000000);
        check("rst_state", 16'(state_o), 16'(ST_RUN));
        check("rst_cnt", stall_cnt_o, 16'h0000);
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // r0 exemption and ALU-source writeback: no hazard.
        drv(RW_RAM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("r0", 6'b000000, 6'b000000);
        drv(RW_ALU, 5'd2, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0);
        chk_out("alu_src", 6'b000000, 6'b000000);
        tick();
        check("r0_state", 16'(state_o), 16'(ST_RUN));
        check("r0_cnt", stall_cnt_o, 16'd0);

        // Load-use on rs; hazard kept on the inputs during LOAD_STALL.
        drv(RW_RAM, 5'd2, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0);
        chk_out("lu_rs", 6'b000011, 6'b000100);
        tick();
        check("lu_state", 16'(state_o), 16'(ST_LOAD_STALL));
        check("lu_cnt", stall_cnt_o, 16'd1);
        chk_out("lu_hold", 6'b000000, 6'b000000);
        tick();
        check("lu_back", 16'(state_o), 16'(ST_RUN));

        // Load-use on rt.
        drv(RW_RAM, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk_out("lu_rt", 6'b000011, 6'b000100);
        tick();
        check("lu_rt_state", 16'(state_o), 16'(ST_LOAD_STALL));
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("lu_rt_cnt", stall_cnt_o, 16'd2);

        // Branch with coincident load-use: two flush cycles, no stall.
        drv(RW_RAM, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        chk_out("br1", 6'b000000, 6'b000010);
        tick();
        check("br_state", 16'(state_o), 16'(ST_BR_FLUSH));
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("br2", 6'b000000, 6'b000010);
        tick();
        check("br_back", 16'(state_o), 16'(ST_RUN));
        chk_out("br3", 6'b000000, 6'b000000);
        check("br_cnt", stall_cnt_o, 16'd2);

        // Memory wait 3 cycles; branch and load-use ignored inside it.
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_out("mw1", 6'b001111, 6'b000000);
        tick();
        check("mw_state", 16'(state_o), 16'(ST_MEM_WAIT));
        drv(RW_RAM, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
        chk_out("mw2", 6'b001111, 6'b000000);
        tick();
        chk_out("mw3", 6'b001111, 6'b000000);
        tick();
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_out("mw_rdy", 6'b000000, 6'b000000);
        tick();
        check("mw_back", 16'(state_o), 16'(ST_RUN));
        check("mw_cnt", stall_cnt_o, 16'd5);

        // Branch, then memory wait for 2 cycles while the flush is pending.
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk_out("bm1", 6'b000000, 6'b000010);
        tick();
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_out("bm2", 6'b001111, 6'b000000);
        tick();
        check("bm_state", 16'(state_o), 16'(ST_BR_FLUSH));
        chk_out("bm3", 6'b001111, 6'b000000);
        tick();
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk_out("bm4", 6'b000000, 6'b000010);
        tick();
        check("bm_back", 16'(state_o), 16'(ST_RUN));
        check("bm_cnt", stall_cnt_o, 16'd7);

        // Load-use followed by a memory wait in LOAD_STALL.
        drv(RW_RAM, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_out("lm1", 6'b001111, 6'b000000);
        tick();
        check("lm_state", 16'(state_o), 16'(ST_MEM_WAIT));
        check("lm_cnt", stall_cnt_o, 16'd9);

        // Reset asserted mid-MEM_WAIT with the wait still on the inputs.
        rst_n = 1'b0;
        #1;
        chk_out("rmw", 6'b000000, 6'b000000);
        check("rmw_state", 16'(state_o), 16'(ST_RUN));
        check("rmw_cnt", stall_cnt_o, 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_out("rmw_run", 6'b001111, 6'b000000);
        tick();
        check("rmw_cnt2", stall_cnt_o, 16'd1);

        // Reset asserted mid-BR_FLUSH discards the pending flush.
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("rbf_pre", 16'(state_o), 16'(ST_BR_FLUSH));
        rst_n = 1'b0;
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_out("rbf", 6'b000000, 6'b000000);
        tick();
        rst_n = 1'b1;
        #1;
        chk_out("rbf_rel", 6'b000000, 6'b000000);
        tick();
        check("rbf_state", 16'(state_o), 16'(ST_RUN));

        // Saturation: hold a memory wait long enough to reach the top.
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", stall_cnt_o, 16'hFFFE);
        tick();
        check("sat_1", stall_cnt_o, 16'hFFFF);
        tick();
        check("sat_2", stall_cnt_o, 16'hFFFF);
        tick();
        check("sat_3", stall_cnt_o, 16'hFFFF);
        drv(RW_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
